// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetch unit: issues sequential fetches, buffers in-order responses in a
// small queue toward decode, and flushes/drops stale responses on a redirect.
module fetch_prefetch_unit #(
    parameter int unsigned     XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(32'h8000_0000),
    parameter int unsigned     QUEUE_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    output logic            mem_req_valid_o,
    input  logic            mem_req_ready_i,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_rsp_valid_i,
    input  logic [XLEN-1:0] mem_rsp_data_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] instr_pc_o
);

    localparam int unsigned     PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned     CW      = PW + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rsp_pc_q;
    logic [XLEN-1:0] data_q [QUEUE_DEPTH];
    logic [XLEN-1:0] ipc_q  [QUEUE_DEPTH];
    logic [PW-1:0]   wptr_q;
    logic [PW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   out_q;
    logic [CW-1:0]   out_d;
    logic [CW-1:0]   stale_q;
    logic            req_hs;
    logic            rsp_live;
    logic            enq;
    logic            deq;
    logic [XLEN-1:0] redirect_tgt;
    logic            unused_pc_bits;

    assign redirect_tgt   = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc_i[1:0];

    // Outstanding requests reserve queue slots, so the queue can never overflow.
    assign mem_req_valid_o = !rst_i && enable_i && !redirect_i &&
                             ((count_q + out_q) < CW'(QUEUE_DEPTH));
    assign mem_addr_o      = pc_q;
    assign req_hs          = mem_req_valid_o && mem_req_ready_i;
    assign out_d           = out_q + CW'(req_hs) - CW'(mem_rsp_valid_i);

    assign rsp_live      = mem_rsp_valid_i && (stale_q == '0);
    assign enq           = rsp_live && !redirect_i;
    assign instr_valid_o = (count_q != '0);
    assign deq           = instr_valid_o && instr_ready_i;
    assign instr_o       = instr_valid_o ? data_q[rptr_q] : '0;
    assign instr_pc_o    = instr_valid_o ? ipc_q[rptr_q]  : '0;

    // Control state; rsp_pc_q tracks the PC of the next non-stale response.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            rsp_pc_q <= RESET_PC;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            out_q    <= '0;
            stale_q  <= '0;
        end else begin
            out_q <= out_d;
            if (redirect_i) begin
                pc_q     <= redirect_tgt;
                rsp_pc_q <= redirect_tgt;
                stale_q  <= out_d;
                wptr_q   <= '0;
                rptr_q   <= '0;
                count_q  <= '0;
            end else begin
                if (req_hs) begin
                    pc_q <= pc_q + PC_STEP;
                end
                if (mem_rsp_valid_i && !rsp_live) begin
                    stale_q <= stale_q - CW'(1);
                end
                if (enq) begin
                    wptr_q   <= wptr_q + PW'(1);
                    rsp_pc_q <= rsp_pc_q + PC_STEP;
                end
                if (deq) begin
                    rptr_q <= rptr_q + PW'(1);
                end
                count_q <= count_q + CW'(enq) - CW'(deq);
            end
        end
    end

    // Queue storage needs no reset; the head is masked while the queue is empty.
    always_ff @(posedge clk_i) begin
        if (enq && !rst_i) begin
            data_q[wptr_q] <= mem_rsp_data_i;
            ipc_q[wptr_q]  <= rsp_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: directed vector table, corner sequences,
// and randomized traffic against an epoch-tagged transaction model.
module tb_fetch_prefetch_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i, enable_i, mem_req_valid_o, mem_req_ready_i, mem_rsp_valid_i;
    logic        redirect_i, instr_valid_o, instr_ready_i;
    logic [31:0] mem_addr_o, mem_rsp_data_i, redirect_pc_i, instr_o, instr_pc_o;

    always #5 clk_i = ~clk_i;

    fetch_prefetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .QUEUE_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_addr_o(mem_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
        .mem_rsp_data_i(mem_rsp_data_i), .redirect_i(redirect_i),
        .redirect_pc_i(redirect_pc_i), .instr_valid_o(instr_valid_o),
        .instr_ready_i(instr_ready_i), .instr_o(instr_o), .instr_pc_o(instr_pc_o)
    );

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ins_t;
    typedef struct {
        logic rst, en, rdy, rsp, redir; logic [31:0] rpc; logic irdy;
        logic e_rv; logic [31:0] e_addr; logic e_iv; logic [31:0] e_pc;
    } vec_t;

    req_t        pend[$];
    ins_t        iq[$];
    logic [31:0] m_pc;
    int          epoch, n_pass, n_total, hs_cnt, hs0;
    vec_t        tbl[13];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic vec_t mk(input logic rst, en, rdy, rsp, redir, input logic [31:0] rpc,
                                input logic irdy, e_rv, input logic [31:0] e_addr,
                                input logic e_iv, input logic [31:0] e_pc);
        vec_t v;
        v.rst = rst; v.en = en; v.rdy = rdy; v.rsp = rsp; v.redir = redir; v.rpc = rpc;
        v.irdy = irdy; v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_pc = e_pc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    endtask

    // Response data always comes from the oldest accepted request.
    task automatic drive(input logic rst, en, rdy, rsp, redir, input logic [31:0] rpc,
                         input logic irdy);
        rst_i = rst; enable_i = en; mem_req_ready_i = rdy; redirect_i = redir;
        redirect_pc_i = rpc; instr_ready_i = irdy;
        mem_rsp_valid_i = rsp && (pend.size() != 0);
        mem_rsp_data_i  = mem_rsp_valid_i ? word_of(pend[0].addr) : 32'h0;
    endtask

    task automatic model_check();
        logic ev;
        ev = enable_i && !redirect_i && ((iq.size() + pend.size()) < DEPTH);
        chk("req_valid", 32'(mem_req_valid_o), 32'(ev));
        chk("mem_addr", mem_addr_o, m_pc);
        chk("instr_valid", 32'(instr_valid_o), 32'(iq.size() != 0));
        if (iq.size() != 0) begin
            chk("instr", instr_o, iq[0].data);
            chk("instr_pc", instr_pc_o, iq[0].pc);
        end
    endtask

    // Apply this cycle's events to the model and memory, then cross the clock edge.
    task automatic advance();
        req_t r;
        ins_t e;
        if (rst_i) begin
            pend.delete(); iq.delete(); m_pc = RPC; epoch++;
        end else begin
            if (instr_ready_i && iq.size() != 0) void'(iq.pop_front());
            if (mem_rsp_valid_i && pend.size() != 0) begin
                r = pend.pop_front();
                if (r.epoch == epoch && !redirect_i) begin
                    e.pc = r.addr; e.data = word_of(r.addr);
                    iq.push_back(e);
                end
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                r.addr = m_pc; r.epoch = epoch;
                pend.push_back(r);
                m_pc = m_pc + 32'd4;
                hs_cnt++;
            end
            if (redirect_i) begin
                iq.delete(); epoch++; m_pc = {redirect_pc_i[31:2], 2'b00};
            end
        end
        @(posedge clk_i); #1;
    endtask

    task automatic cyc(input logic rst, en, rdy, rsp, redir, input logic [31:0] rpc,
                       input logic irdy);
        drive(rst, en, rdy, rsp, redir, rpc, irdy);
        @(negedge clk_i);
        if (!rst) model_check();
        advance();
    endtask

    task automatic reset_dut();
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        n_pass = 0; n_total = 0; hs_cnt = 0; epoch = 0; m_pc = RPC;
        drive(1, 0, 0, 0, 0, 0, 0);

        // Back-to-back fetch, then redirect to 0x80000103 with three requests in flight.
        tbl[0]  = mk(0,0,0,0,0,0,0,           0, 32'h8000_0000, 0, 32'h0);
        tbl[1]  = mk(0,1,1,0,0,0,1,           1, 32'h8000_0000, 0, 32'h0);
        tbl[2]  = mk(0,1,1,1,0,0,1,           1, 32'h8000_0004, 0, 32'h0);
        tbl[3]  = mk(0,1,1,1,0,0,1,           1, 32'h8000_0008, 1, 32'h8000_0000);
        tbl[4]  = mk(0,1,1,1,0,0,1,           1, 32'h8000_000C, 1, 32'h8000_0004);
        tbl[5]  = mk(0,1,1,0,0,0,1,           1, 32'h8000_0010, 1, 32'h8000_0008);
        tbl[6]  = mk(0,1,1,0,0,0,1,           1, 32'h8000_0014, 0, 32'h0);
        tbl[7]  = mk(0,1,1,0,1,32'h8000_0103,1, 0, 32'h8000_0018, 0, 32'h0);
        tbl[8]  = mk(0,1,1,1,0,0,1,           1, 32'h8000_0100, 0, 32'h0);
        tbl[9]  = mk(0,1,1,1,0,0,1,           1, 32'h8000_0104, 0, 32'h0);
        tbl[10] = mk(0,1,1,1,0,0,1,           1, 32'h8000_0108, 0, 32'h0);
        tbl[11] = mk(0,1,1,1,0,0,1,           1, 32'h8000_010C, 0, 32'h0);
        tbl[12] = mk(0,1,0,0,0,0,0,           0, 32'h8000_0110, 1, 32'h8000_0100);

        reset_dut();
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].rdy, tbl[i].rsp, tbl[i].redir,
                  tbl[i].rpc, tbl[i].irdy);
            @(negedge clk_i);
            chk($sformatf("vec%0d_req_valid", i), 32'(mem_req_valid_o), 32'(tbl[i].e_rv));
            chk($sformatf("vec%0d_addr", i), mem_addr_o, tbl[i].e_addr);
            chk($sformatf("vec%0d_instr_valid", i), 32'(instr_valid_o), 32'(tbl[i].e_iv));
            if (i == 0 || tbl[i].e_iv) begin
                chk($sformatf("vec%0d_instr_pc", i), instr_pc_o, tbl[i].e_pc);
                chk($sformatf("vec%0d_instr", i), instr_o,
                    tbl[i].e_iv ? word_of(tbl[i].e_pc) : 32'h0);
            end
            advance();
        end

        // Decode stalled: queue fills with exactly DEPTH requests; one dequeue frees one slot.
        reset_dut();
        hs0 = hs_cnt;
        repeat (12) cyc(0, 1, 1, 1, 0, 0, 0);
        chk("backpressure_reqs", 32'(hs_cnt - hs0), 32'(DEPTH));
        hs0 = hs_cnt;
        cyc(0, 1, 1, 1, 0, 0, 1);
        repeat (8) cyc(0, 1, 1, 1, 0, 0, 0);
        chk("one_dequeue_one_req", 32'(hs_cnt - hs0), 32'd1);

        // Memory not ready: request and address held for five cycles.
        reset_dut();
        repeat (5) begin
            drive(0, 1, 0, 0, 0, 0, 1);
            @(negedge clk_i);
            chk("stall_valid", 32'(mem_req_valid_o), 32'd1);
            chk("stall_addr", mem_addr_o, RPC);
            model_check();
            advance();
        end

        // Redirect while disabled, then the PC wraps past the top of the address space.
        reset_dut();
        cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFE, 1);
        drive(0, 1, 1, 0, 0, 0, 1);
        @(negedge clk_i);
        chk("wrap_target", mem_addr_o, 32'hFFFF_FFFC);
        model_check();
        advance();
        drive(0, 1, 1, 1, 0, 0, 1);
        @(negedge clk_i);
        chk("wrap_next", mem_addr_o, 32'h0000_0000);
        model_check();
        advance();

        // Reset with two queued and two outstanding, colliding with redirect and handshakes.
        reset_dut();
        repeat (2) cyc(0, 1, 1, 0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 1, 0, 0, 0);
        repeat (2) cyc(0, 1, 1, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 32'h0000_1234, 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
        chk("rst_addr", mem_addr_o, RPC);
        chk("rst_instr_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instr_o, 32'h0);
        chk("rst_instr_pc", instr_pc_o, 32'h0);
        advance();
        drive(0, 1, 1, 0, 0, 0, 1);
        @(negedge clk_i);
        chk("first_req_valid", 32'(mem_req_valid_o), 32'd1);
        chk("first_req_addr", mem_addr_o, RPC);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : (32'h8000_0000 | 32'($urandom_range(0, 4095)));
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                $urandom_range(0, 19) == 0, tgt, $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
